booth_mul_seq: RTL and testbench

- Multi-cycle signed 32x32 -> 64-bit multiplier controller for the ALU's MUL instruction.
- Implements radix-2 Booth's algorithm. The single shared 32-bit CLA adder performs every add/subtract of the multiplicand, one Booth step per clock.
- Sits beside the combinational ALU ops. Results go to the HI/LO register pair. The control unit holds the ALU in the MUL step while busy is high.

---
 rtl/booth_mul_seq_pkg.sv | 29 ++
 rtl/booth_mul_seq_cla.sv | 41 ++++
 rtl/booth_mul_seq.sv | 136 +++++++++++++
 tb/tb_booth_mul_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM encodings, Booth pair codes and the step count.
package booth_mul_seq_pkg;

  localparam int MUL_STEPS = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Booth pair is {Q[0], Q_-1}
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_e;

  function automatic booth_op_e booth_decode(input logic [1:0] pair);
    case (pair)
      PAIR_ADD: return OP_ADD;
      PAIR_SUB: return OP_SUB;
      default:  return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mul_seq_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained group to group.
module CLA_32bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [32:0] carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int grp = 0; grp < 8; grp++) begin
      carry[grp*4+1] = gen[grp*4] | (prop[grp*4] & carry[grp*4]);
      carry[grp*4+2] = gen[grp*4+1]
                     | (prop[grp*4+1] & gen[grp*4])
                     | (prop[grp*4+1] & prop[grp*4] & carry[grp*4]);
      carry[grp*4+3] = gen[grp*4+2]
                     | (prop[grp*4+2] & gen[grp*4+1])
                     | (prop[grp*4+2] & prop[grp*4+1] & gen[grp*4])
                     | (prop[grp*4+2] & prop[grp*4+1] & prop[grp*4] & carry[grp*4]);
      carry[grp*4+4] = gen[grp*4+3]
                     | (prop[grp*4+3] & gen[grp*4+2])
                     | (prop[grp*4+3] & prop[grp*4+2] & gen[grp*4+1])
                     | (prop[grp*4+3] & prop[grp*4+2] & prop[grp*4+1] & gen[grp*4])
                     | (prop[grp*4+3] & prop[grp*4+2] & prop[grp*4+1] & prop[grp*4]
                        & carry[grp*4]);
    end
  end

  assign sum  = prop ^ carry[31:0];
  assign cout = carry[32];

endmodule

// File: rtl/booth_mul_seq.sv
// Multi-cycle signed 32x32->64 radix-2 Booth multiplier, one step per clock
// through a single shared CLA adder. Product lands in HI/LO on entry to DONE.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  booth_op_e        op;
  logic [WIDTH-1:0] opb;
  logic             opb_sign;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;

  always_comb begin
    op       = booth_decode({q_q[0], qm1_q});
    opb      = '0;
    opb_sign = 1'b0;
    cin      = 1'b0;
    case (op)
      OP_ADD: begin
        opb      = m_q;
        opb_sign = m_q[WIDTH-1];
      end
      OP_SUB: begin
        opb      = ~m_q;
        opb_sign = ~m_q[WIDTH-1];
        cin      = 1'b1;
      end
      default: ;
    endcase
  end

  CLA_32bit_adder u_cla (
    .a    (acc_q[WIDTH-1:0]),
    .b    (opb),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // The 33rd accumulator bit is rebuilt from the adder carry-out so that
  // M = 0x80000000 is handled exactly without a wider adder.
  assign acc_sum = {acc_q[WIDTH] ^ opb_sign ^ cout, sum};
  assign acc_sh  = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
  assign q_sh    = {acc_sum[0], q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d     = mcand;
          q_d     = mplier;
          acc_d   = '0;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_sh;
        q_d     = q_sh;
        qm1_d   = q_q[0];
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(MUL_STEPS - 1)) begin
          hi_d    = acc_sh[WIDTH-1:0];
          lo_d    = q_sh;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: fixed vectors, multi-cycle corner
// sequences and random operands against a plain signed-multiply reference.
module tb_booth_mul_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[6];

  always #5 clock = ~clock;

  booth_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .busy   (busy),
    .done   (done),
    .HI     (hi),
    .LO     (lo)
  );

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7, 0))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents an operation request for one edge; returns just after that edge
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    mcand  = $urandom;
    mplier = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] prod);
    int lat;
    int busy_cnt;
    apply_stimulus(a, b);
    wait_done(lat, busy_cnt);
    check_output({name, " latency"}, 64'(lat), 64'd32);
    check_output({name, " busy cycles"}, 64'(busy_cnt), 64'd32);
    check_output({name, " product"}, {hi, lo}, prod);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int busy_cnt;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{"6x7",         32'd6,          32'd7,          64'h0000_0000_0000_002A};
    vecs[1] = '{"-3x5",        32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{"minxmin",     32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[3] = '{"-1x-1",       32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
    vecs[4] = '{"maxx2",       32'h7FFF_FFFF,  32'd2,          64'h0000_0000_FFFF_FFFE};
    vecs[5] = '{"9x9",         32'd9,          32'd9,          64'h0000_0000_0000_0051};

    clear  = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #12;
    check_output("reset flags", {62'd0, busy, done}, 64'd0);
    check_output("reset product", {hi, lo}, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_and_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].prod);
      tick();
      check_output({vecs[i].name, " idle after done"}, {62'd0, busy, done}, 64'd0);
    end

    // Back-to-back: start held during DONE reloads with no idle cycle
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, busy_cnt);
    check_output("b2b first product", {hi, lo}, 64'd1);
    apply_stimulus(32'd2, 32'd3);
    check_output("b2b no dead cycle", {62'd0, busy, done}, 64'd2);
    check_output("b2b hold during run", {hi, lo}, 64'd1);
    wait_done(lat, busy_cnt);
    check_output("b2b second latency", 64'(lat), 64'd32);
    check_output("b2b second product", {hi, lo}, 64'd6);
    tick();

    // A start pulse at step 10 of a running op must be ignored
    apply_stimulus(32'd9, 32'd9);
    repeat (9) tick();
    mcand  = 32'd1;
    mplier = 32'd1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(lat, busy_cnt);
    check_output("ignored start latency", 64'(lat), 64'd22);
    check_output("ignored start product", {hi, lo}, 64'd81);
    tick();
    check_output("ignored start single done", {62'd0, busy, done}, 64'd0);

    // Clear during step 20 aborts immediately and zeroes outputs
    apply_stimulus(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (19) tick();
    check_output("pre-clear busy", {62'd0, busy, done}, 64'd2);
    clear = 1'b0;
    #1;
    check_output("clear flags", {62'd0, busy, done}, 64'd0);
    check_output("clear product", {hi, lo}, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    tick();
    run_and_check("restart maxx2", 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE);

    for (int i = 0; i < 250; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      if ($urandom_range(1, 0) == 0) begin
        tick();
        check_output("random done pulse once", {62'd0, busy, done}, 64'd0);
      end
      run_and_check("random", ra, rb, ref_product(ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
